zcash_fpga_cmd_parser: RTL and testbench
========================================

Name: zcash_fpga_cmd_parser

Overview:
- Ingress stage between the host RX stream and the command engines; the reply-building stage sits downstream of it.
- Consumes 64-bit little-endian-word host messages, each starting with an 8-byte `header_t` word: cmd in [63:32], len in bytes in [31:0].
- Handles typ0 commands locally as request pulses: RESET_FPGA 0x0000_0000, FPGA_STATUS 0x0000_0001.
- Forwards typ1 commands to the selected engine: VERIFY_EQUIHASH 0x0000_0100, VERIFY_SECP256K1_SIG 0x0000_0101.
- Drops unknown or disabled commands and raises an ignore request carrying the offending header.

Parameters:
- ENB_EQUIHASH, 0, 1 = VERIFY_EQUIHASH is routed; 0 = it is treated as unknown.
- ENB_SECP256K1, 1, 1 = VERIFY_SECP256K1_SIG is routed; 0 = it is treated as unknown.
- MAX_LEN, 2048, largest legal len in bytes; a larger len is treated as an error.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_rx_dat  in  64  host data word
- i_rx_val  in  1  word valid
- i_rx_sop  in  1  first word of message (header)
- i_rx_eop  in  1  last word of message
- o_rx_rdy  out  1  parser accepts word
- o_eng_dat  out  64  forwarded word, header included
- o_eng_val  out  1  forwarded valid
- o_eng_sop  out  1  forwarded sop
- o_eng_eop  out  1  forwarded eop
- o_eng_sel  out  1  0 = equihash engine, 1 = secp256k1 engine; held stable for the whole message
- i_eng_rdy  in  1  engine ready
- o_reset_req  out  1  one-cycle pulse, RESET_FPGA received
- o_status_req  out  1  one-cycle pulse, FPGA_STATUS received
- o_ign_hdr  out  64  header of dropped message
- o_ign_val  out  1  ignore reply request
- i_ign_rdy  in  1  ignore request accepted
- o_state  out  3  typ1_state debug encoding
- o_error  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: all outputs are 0, state is IDLE, o_error is 0.
- State encoding for o_state: IDLE=0, FWD=1, DROP=2, IGN=3, LOCAL=4.
- Handshake: a word transfers when val && rdy on the same edge.
- o_rx_rdy per state:
  - IDLE: 1.
  - FWD: equals i_eng_rdy (combinational passthrough, zero latency).
  - DROP and LOCAL: 1.
  - IGN: 0.

IDLE, on an accepted word with i_rx_sop=1 (header decoded from i_rx_dat):
- cmd 0x0000_0000 or 0x0000_0001 → pulse o_reset_req / o_status_req on the next cycle.
  - If eop is on the same word: stay in IDLE.
  - Otherwise: go to LOCAL and discard the rest.
- Enabled VERIFY_* with 8 <= len <= MAX_LEN → drive o_eng_sel and go to FWD.
  - In IDLE, o_eng_val = i_rx_val && routed-cmd && i_eng_rdy gating, so the header word is forwarded in the same cycle.
  - If eop is on the header word: stay in IDLE.
- Any other cmd, or a bad len:
  - Latch o_ign_hdr = i_rx_dat.
  - Go to DROP, or straight to IGN if eop is on the header word.
  - Set o_error if the len was bad.

IDLE, on an accepted word with i_rx_sop=0:
- Discard the word and set o_error.

FWD:
- Pass through dat, val, sop=0 and eop.
- On an accepted eop → IDLE.
- A word with i_rx_sop=1 arriving in FWD:
  - Force o_eng_eop=1 on that word and set o_error.
  - The word is consumed, not reparsed.

DROP:
- Consume words until an accepted eop, then go to IGN.

IGN:
- o_ign_val=1 until i_ign_rdy, then go to IDLE.
- o_ign_hdr is held stable while o_ign_val=1.

LOCAL:
- Consume words until eop, then go to IDLE.

Word counting:
- The word counter loads ceil(len/8) on the header and decrements on each accepted word.
- It is 9 bits wide, with no wrap for MAX_LEN ≤ 4088.

Reset mid-message:
- The parser returns to IDLE immediately and drops pending ignore or pulse requests.
- The downstream engine receives no eop; engines share i_rst.

Simultaneous events:
- An eop accepted in FWD and a new sop word can never appear on the same cycle (one word per cycle).

Optional Feature:
- Macro: ZCASH_CMD_LEN_CHECK_EN.
- When defined:
  - An eop arriving before the counter reaches 1, or the counter reaching 0 without eop, sets o_error.
  - In FWD, the word where the counter hits 1 is forced to o_eng_eop=1 and the parser goes to DROP-silent (consume to eop, no ignore request).
- When undefined:
  - The counter is omitted and eop alone delimits messages.
  - The len range check in IDLE is still performed.

Test Plan:
- Header {0x0000_0001, 8} with sop=eop → o_status_req pulses once one cycle later; o_rx_rdy stays 1; o_error=0.
- SECP256K1=1, header {0x0000_0101, 0xD0} followed by 25 more words (26 total), eop on the last, i_eng_rdy toggling 1/0 → all 26 words appear on eng in order with o_eng_sel=1, sop only on the first word, eop on word 26, no loss.
- ENB_EQUIHASH=0, header {0x0000_0100, 0x10}, 2 words → nothing is forwarded; o_ign_val=1 with o_ign_hdr=0x0000_0100_0000_0010, held until i_ign_rdy; then IDLE.
- Header {0xDEAD_BEEF, 8}, i_ign_rdy held 0 for 5 cycles → o_rx_rdy=0 during IGN; the ignore request completes when i_ign_rdy is raised.
- With ZCASH_CMD_LEN_CHECK_EN, VERIFY_SECP256K1 len=0xD0 but eop on word 10 → o_error=1 and the parser returns to IDLE after that eop.
- i_rst asserted mid-FWD at word 5 → next cycle all outputs are 0 and state is IDLE; a following status header is parsed normally.

Source files
------------

// File: rtl/zcash_fpga_cmd_parser.sv
// Host command parser: decodes message headers, fires local request pulses, routes verify commands
// to an engine and drops everything else. Optional feature macro: ZCASH_CMD_LEN_CHECK_EN.
module zcash_fpga_cmd_parser #(
    parameter bit ENB_EQUIHASH  = 1'b0,
    parameter bit ENB_SECP256K1 = 1'b1,
    parameter int MAX_LEN       = 2048
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_rx_dat,
    input  logic        i_rx_val,
    input  logic        i_rx_sop,
    input  logic        i_rx_eop,
    output logic        o_rx_rdy,
    output logic [63:0] o_eng_dat,
    output logic        o_eng_val,
    output logic        o_eng_sop,
    output logic        o_eng_eop,
    output logic        o_eng_sel,
    input  logic        i_eng_rdy,
    output logic        o_reset_req,
    output logic        o_status_req,
    output logic [63:0] o_ign_hdr,
    output logic        o_ign_val,
    input  logic        i_ign_rdy,
    output logic [2:0]  o_state,
    output logic        o_error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FWD   = 3'd1,
        DROP  = 3'd2,
        IGN   = 3'd3,
        LOCAL = 3'd4
    } state_t;

    localparam logic [31:0] CMD_RESET_FPGA  = 32'h0000_0000;
    localparam logic [31:0] CMD_FPGA_STATUS = 32'h0000_0001;
    localparam logic [31:0] CMD_VERIFY_EQUI = 32'h0000_0100;
    localparam logic [31:0] CMD_VERIFY_SECP = 32'h0000_0101;

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic [63:0] ignHdr_q, ignHdr_d;
    logic        error_q, error_d;
    logic        resetReq_q, resetReq_d;
    logic        statusReq_q, statusReq_d;
    logic        silent_q, silent_d;

    logic [31:0] hdrCmd;
    logic [31:0] hdrLen;
    logic        isLocal;
    logic        isEqui;
    logic        isSecp;
    logic        isVerify;
    logic        lenOk;
    logic        routedHdr;

    logic        rxRdy;
    logic        fwdPath;
    logic        engVal;
    logic        engSop;
    logic        engEop;
    logic        engSel;

`ifdef ZCASH_CMD_LEN_CHECK_EN
    logic [8:0]  cnt_q, cnt_d;
    logic [8:0]  hdrWords;
    assign hdrWords = 9'((hdrLen + 32'd7) >> 3);
`endif

    // Header decode is evaluated on every word; it only matters when a sop word is seen in IDLE.
    assign hdrCmd    = i_rx_dat[63:32];
    assign hdrLen    = i_rx_dat[31:0];
    assign isLocal   = (hdrCmd == CMD_RESET_FPGA) || (hdrCmd == CMD_FPGA_STATUS);
    assign isEqui    = ENB_EQUIHASH  && (hdrCmd == CMD_VERIFY_EQUI);
    assign isSecp    = ENB_SECP256K1 && (hdrCmd == CMD_VERIFY_SECP);
    assign isVerify  = isEqui || isSecp;
    assign lenOk     = (hdrLen >= 32'd8) && (hdrLen <= 32'(MAX_LEN));
    assign routedHdr = i_rx_sop && isVerify && lenOk;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            ignHdr_q    <= '0;
            error_q     <= 1'b0;
            resetReq_q  <= 1'b0;
            statusReq_q <= 1'b0;
            silent_q    <= 1'b0;
`ifdef ZCASH_CMD_LEN_CHECK_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ignHdr_q    <= ignHdr_d;
            error_q     <= error_d;
            resetReq_q  <= resetReq_d;
            statusReq_q <= statusReq_d;
            silent_q    <= silent_d;
`ifdef ZCASH_CMD_LEN_CHECK_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ignHdr_d    = ignHdr_q;
        error_d     = error_q;
        resetReq_d  = 1'b0;
        statusReq_d = 1'b0;
        silent_d    = silent_q;
        rxRdy       = 1'b0;
        fwdPath     = 1'b0;
        engVal      = 1'b0;
        engSop      = 1'b0;
        engEop      = 1'b0;
        engSel      = sel_q;
`ifdef ZCASH_CMD_LEN_CHECK_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                rxRdy = 1'b1;
                // Routed headers go straight through in the same cycle, qualified by engine ready.
                if (routedHdr) begin
                    fwdPath = 1'b1;
                    engSel  = isSecp;
                    engVal  = i_rx_val && i_eng_rdy;
                    engSop  = 1'b1;
                    engEop  = i_rx_eop;
`ifdef ZCASH_CMD_LEN_CHECK_EN
                    engEop  = i_rx_eop || (hdrWords == 9'd1);
`endif
                end
                if (i_rx_val) begin
                    if (!i_rx_sop) begin
                        error_d = 1'b1;
                    end else if (isLocal) begin
                        resetReq_d  = (hdrCmd == CMD_RESET_FPGA);
                        statusReq_d = (hdrCmd == CMD_FPGA_STATUS);
                        if (!i_rx_eop) begin
                            state_d = LOCAL;
                        end
                    end else if (routedHdr) begin
                        sel_d = isSecp;
`ifdef ZCASH_CMD_LEN_CHECK_EN
                        cnt_d = hdrWords - 9'd1;
                        if (i_rx_eop && (hdrWords != 9'd1)) begin
                            error_d = 1'b1;
                        end
                        if (i_rx_eop) begin
                            state_d = IDLE;
                        end else if (hdrWords == 9'd1) begin
                            error_d  = 1'b1;
                            silent_d = 1'b1;
                            state_d  = DROP;
                        end else begin
                            state_d = FWD;
                        end
`else
                        if (!i_rx_eop) begin
                            state_d = FWD;
                        end
`endif
                    end else begin
                        ignHdr_d = i_rx_dat;
                        silent_d = 1'b0;
                        state_d  = i_rx_eop ? IGN : DROP;
                        if (isVerify && !lenOk) begin
                            error_d = 1'b1;
                        end
                    end
                end
            end

            FWD: begin
                rxRdy   = i_eng_rdy;
                fwdPath = 1'b1;
                engVal  = i_rx_val;
                // A stray sop closes the current message rather than starting a new one.
                engEop  = i_rx_eop || i_rx_sop;
`ifdef ZCASH_CMD_LEN_CHECK_EN
                engEop  = i_rx_eop || i_rx_sop || (cnt_q == 9'd1);
`endif
                if (i_rx_val && i_eng_rdy) begin
                    if (i_rx_sop) begin
                        error_d = 1'b1;
                    end
`ifdef ZCASH_CMD_LEN_CHECK_EN
                    cnt_d = cnt_q - 9'd1;
                    if (i_rx_eop && (cnt_q != 9'd1)) begin
                        error_d = 1'b1;
                    end
`endif
                    if (i_rx_eop || i_rx_sop) begin
                        state_d = IDLE;
`ifdef ZCASH_CMD_LEN_CHECK_EN
                    end else if (cnt_q == 9'd1) begin
                        error_d  = 1'b1;
                        silent_d = 1'b1;
                        state_d  = DROP;
`endif
                    end
                end
            end

            DROP: begin
                rxRdy = 1'b1;
                if (i_rx_val && i_rx_eop) begin
                    state_d  = silent_q ? IDLE : IGN;
                    silent_d = 1'b0;
                end
            end

            IGN: begin
                rxRdy = 1'b0;
                if (i_ign_rdy) begin
                    state_d = IDLE;
                end
            end

            LOCAL: begin
                rxRdy = 1'b1;
                if (i_rx_val && i_rx_eop) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Combinational outputs are forced low while reset is held so the ports read all-zero.
    assign o_rx_rdy     = rxRdy && !i_rst;
    assign o_eng_dat    = (fwdPath && !i_rst) ? i_rx_dat : '0;
    assign o_eng_val    = engVal && !i_rst;
    assign o_eng_sop    = engSop && engVal && !i_rst;
    assign o_eng_eop    = engEop && engVal && !i_rst;
    assign o_eng_sel    = engSel && !i_rst;
    assign o_reset_req  = resetReq_q;
    assign o_status_req = statusReq_q;
    assign o_ign_hdr    = ignHdr_q;
    assign o_ign_val    = (state_q == IGN);
    assign o_state      = state_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_zcash_fpga_cmd_parser.sv
// Directed vector bench for zcash_fpga_cmd_parser: a vector table followed by
// hand-written multi-cycle sequences (ignore backpressure, long forward, reset, length check).
module tb_zcash_fpga_cmd_parser;

    logic        clk;
    logic        rst;
    logic [63:0] rxDat;
    logic        rxVal;
    logic        rxSop;
    logic        rxEop;
    logic        rxRdy;
    logic [63:0] engDat;
    logic        engVal;
    logic        engSop;
    logic        engEop;
    logic        engSel;
    logic        engRdy;
    logic        resetReq;
    logic        statusReq;
    logic [63:0] ignHdr;
    logic        ignVal;
    logic        ignRdy;
    logic [2:0]  state;
    logic        error;

    int checkCount;
    int failCount;

    zcash_fpga_cmd_parser dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_dat     (rxDat),
        .i_rx_val     (rxVal),
        .i_rx_sop     (rxSop),
        .i_rx_eop     (rxEop),
        .o_rx_rdy     (rxRdy),
        .o_eng_dat    (engDat),
        .o_eng_val    (engVal),
        .o_eng_sop    (engSop),
        .o_eng_eop    (engEop),
        .o_eng_sel    (engSel),
        .i_eng_rdy    (engRdy),
        .o_reset_req  (resetReq),
        .o_status_req (statusReq),
        .o_ign_hdr    (ignHdr),
        .o_ign_val    (ignVal),
        .i_ign_rdy    (ignRdy),
        .o_state      (state),
        .o_error      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Flag order: rxRdy engVal engSop engEop engSel resetReq statusReq ignVal error
    typedef struct {
        logic        rst;
        logic        val;
        logic        sop;
        logic        eop;
        logic [63:0] dat;
        logic        engRdy;
        logic        ignRdy;
        logic [8:0]  expFlags;
        logic [2:0]  expState;
        logic [63:0] expIgnHdr;
    } vector_t;

    vector_t vecs[31];

    function automatic vector_t mkVec(input logic r, input logic v, input logic s, input logic e,
                                      input logic [63:0] d, input logic er, input logic ir,
                                      input logic [8:0] f, input logic [2:0] st, input logic [63:0] ih);
        vector_t x;
        x.rst = r; x.val = v; x.sop = s; x.eop = e; x.dat = d;
        x.engRdy = er; x.ignRdy = ir;
        x.expFlags = f; x.expState = st; x.expIgnHdr = ih;
        return x;
    endfunction

    function automatic logic [8:0] actFlags();
        return {rxRdy, engVal, engSop, engEop, engSel, resetReq, statusReq, ignVal, error};
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic s, input logic e,
                                 input logic [63:0] d, input logic er, input logic ir);
        @(negedge clk);
        rst    = r;
        rxVal  = v;
        rxSop  = s;
        rxEop  = e;
        rxDat  = d;
        engRdy = er;
        ignRdy = ir;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [63:0] words[26];
    int          sendIdx;
    int          rcvIdx;

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1; rxVal = 1'b0; rxSop = 1'b0; rxEop = 1'b0; rxDat = '0;
        engRdy = 1'b0; ignRdy = 1'b0;

        vecs[0]  = mkVec(1,0,0,0, 64'h0,                    0,0, 9'b000000000, 3'd0, 64'h0);
        vecs[1]  = mkVec(0,1,1,1, {32'h1,   32'h8},         0,0, 9'b100000000, 3'd0, 64'h0);
        vecs[2]  = mkVec(0,0,0,0, 64'h0,                    0,0, 9'b100000100, 3'd0, 64'h0);
        vecs[3]  = mkVec(0,0,0,0, 64'h0,                    0,0, 9'b100000000, 3'd0, 64'h0);
        vecs[4]  = mkVec(0,1,1,0, {32'h0,   32'h8},         0,0, 9'b100000000, 3'd0, 64'h0);
        vecs[5]  = mkVec(0,1,0,0, 64'h1111,                 0,0, 9'b100001000, 3'd4, 64'h0);
        vecs[6]  = mkVec(0,1,0,1, 64'h2222,                 0,0, 9'b100000000, 3'd4, 64'h0);
        vecs[7]  = mkVec(0,0,0,0, 64'h0,                    0,0, 9'b100000000, 3'd0, 64'h0);
        vecs[8]  = mkVec(0,1,0,0, 64'h3333,                 0,0, 9'b100000000, 3'd0, 64'h0);
        vecs[9]  = mkVec(0,0,0,0, 64'h0,                    0,0, 9'b100000001, 3'd0, 64'h0);
        vecs[10] = mkVec(1,0,0,0, 64'h0,                    0,0, 9'b000000001, 3'd0, 64'h0);
        vecs[11] = mkVec(0,0,0,0, 64'h0,                    0,0, 9'b100000000, 3'd0, 64'h0);
        vecs[12] = mkVec(0,1,1,0, {32'h100, 32'h10},        1,0, 9'b100000000, 3'd0, 64'h0);
        vecs[13] = mkVec(0,1,0,1, 64'h4444,                 1,0, 9'b100000000, 3'd2, 64'h0);
        vecs[14] = mkVec(0,0,0,0, 64'h0,                    0,0, 9'b000000010, 3'd3, 64'h0000_0100_0000_0010);
        vecs[15] = mkVec(0,0,0,0, 64'h0,                    0,1, 9'b000000010, 3'd3, 64'h0000_0100_0000_0010);
        vecs[16] = mkVec(0,0,0,0, 64'h0,                    0,0, 9'b100000000, 3'd0, 64'h0);
        vecs[17] = mkVec(0,1,1,1, {32'h101, 32'h1000},      1,0, 9'b100000000, 3'd0, 64'h0);
        vecs[18] = mkVec(0,0,0,0, 64'h0,                    0,1, 9'b000000011, 3'd3, 64'h0000_0101_0000_1000);
        vecs[19] = mkVec(0,0,0,0, 64'h0,                    0,0, 9'b100000001, 3'd0, 64'h0);
        vecs[20] = mkVec(1,0,0,0, 64'h0,                    0,0, 9'b000000001, 3'd0, 64'h0);
        vecs[21] = mkVec(0,0,0,0, 64'h0,                    0,0, 9'b100000000, 3'd0, 64'h0);
        vecs[22] = mkVec(0,1,1,0, {32'h101, 32'h10},        1,0, 9'b111010000, 3'd0, 64'h0);
        vecs[23] = mkVec(0,1,0,1, 64'h5555,                 0,0, 9'b010110000, 3'd1, 64'h0);
        vecs[24] = mkVec(0,1,0,1, 64'h5555,                 1,0, 9'b110110000, 3'd1, 64'h0);
        vecs[25] = mkVec(0,0,0,0, 64'h0,                    0,0, 9'b100010000, 3'd0, 64'h0);
        vecs[26] = mkVec(0,1,1,0, {32'h101, 32'h18},        1,0, 9'b111010000, 3'd0, 64'h0);
        vecs[27] = mkVec(0,1,1,0, 64'h6666,                 1,0, 9'b110110000, 3'd1, 64'h0);
        vecs[28] = mkVec(0,0,0,0, 64'h0,                    0,0, 9'b100010001, 3'd0, 64'h0);
        vecs[29] = mkVec(1,0,0,0, 64'h0,                    0,0, 9'b000000001, 3'd0, 64'h0);
        vecs[30] = mkVec(0,0,0,0, 64'h0,                    0,0, 9'b100000000, 3'd0, 64'h0);

        // Table: outputs are sampled after the inputs settle and before the next rising edge.
        for (int i = 0; i < 31; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].val, vecs[i].sop, vecs[i].eop,
                          vecs[i].dat, vecs[i].engRdy, vecs[i].ignRdy);
            checkOutput($sformatf("vec%0d_flags", i), 64'(actFlags()), 64'(vecs[i].expFlags));
            checkOutput($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].expState));
            if (vecs[i].expFlags[7])
                checkOutput($sformatf("vec%0d_engdat", i), engDat, vecs[i].dat);
            if (vecs[i].expFlags[1])
                checkOutput($sformatf("vec%0d_ignhdr", i), ignHdr, vecs[i].expIgnHdr);
        end

        // Unknown command with the ignore acceptor stalled for five cycles.
        $display("[TB] unknown command with ignore backpressure");
        applyStimulus(0,1,1,1, 64'hDEAD_BEEF_0000_0008, 0,0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0,0,0,0, 64'h0, 0,0);
            checkOutput("ign_wait_rxrdy", 64'(rxRdy), 64'd0);
            checkOutput("ign_wait_val", 64'(ignVal), 64'd1);
            checkOutput("ign_wait_hdr", ignHdr, 64'hDEAD_BEEF_0000_0008);
        end
        applyStimulus(0,0,0,0, 64'h0, 0,1);
        checkOutput("ign_accept_val", 64'(ignVal), 64'd1);
        applyStimulus(0,0,0,0, 64'h0, 0,0);
        checkOutput("ign_done_state", 64'(state), 64'd0);
        checkOutput("ign_done_val", 64'(ignVal), 64'd0);
        checkOutput("ign_done_err", 64'(error), 64'd0);

        // 26-word secp256k1 message with engine ready toggling.
        $display("[TB] long forward with toggling engine ready");
        words[0] = {32'h0000_0101, 32'h0000_00D0};
        for (int k = 1; k < 26; k++)
            words[k] = {32'hC0DE_0000 + 32'(k), 32'h1234_0000 + 32'(k)};
        sendIdx = 0;
        rcvIdx  = 0;
        for (int cyc = 0; cyc < 200 && rcvIdx < 26; cyc++) begin
            applyStimulus(0, sendIdx < 26, sendIdx == 0, sendIdx == 25,
                          (sendIdx < 26) ? words[sendIdx] : 64'h0,
                          (sendIdx == 0) ? 1'b1 : ((cyc % 2) == 1), 0);
            if (engVal && engRdy) begin
                checkOutput($sformatf("fwd_dat%0d", rcvIdx), engDat, words[rcvIdx]);
                checkOutput($sformatf("fwd_flags%0d", rcvIdx), 64'({engSop, engEop, engSel}),
                            64'({rcvIdx == 0, rcvIdx == 25, 1'b1}));
                rcvIdx++;
            end
            if (rxVal && rxRdy)
                sendIdx++;
        end
        checkOutput("fwd_count", 64'(rcvIdx), 64'd26);
        applyStimulus(0,0,0,0, 64'h0, 0,0);
        checkOutput("fwd_end_state", 64'(state), 64'd0);
        checkOutput("fwd_end_err", 64'(error), 64'd0);

        // Reset asserted on the fifth word of a forwarded message.
        $display("[TB] reset in the middle of a forward");
        applyStimulus(0,1,1,0, words[0], 1,0);
        for (int k = 1; k < 5; k++)
            applyStimulus(0,1,0,0, words[k], 1,0);
        checkOutput("rst_pre_state", 64'(state), 64'd1);
        applyStimulus(1,1,0,0, words[5], 1,0);
        applyStimulus(1,1,0,0, words[5], 1,0);
        checkOutput("rst_flags", 64'(actFlags()), 64'd0);
        checkOutput("rst_state", 64'(state), 64'd0);
        checkOutput("rst_engdat", engDat, 64'd0);
        checkOutput("rst_ignhdr", ignHdr, 64'd0);
        applyStimulus(0,1,1,1, {32'h1, 32'h8}, 0,0);
        checkOutput("rst_after_rxrdy", 64'(rxRdy), 64'd1);
        applyStimulus(0,0,0,0, 64'h0, 0,0);
        checkOutput("rst_after_status", 64'(statusReq), 64'd1);
        checkOutput("rst_after_state", 64'(state), 64'd0);

`ifdef ZCASH_CMD_LEN_CHECK_EN
        // Declared length of 26 words but eop arrives on word 10.
        $display("[TB] early eop with length check");
        applyStimulus(0,1,1,0, words[0], 1,0);
        for (int k = 1; k < 10; k++) begin
            applyStimulus(0,1,0,k == 9, words[k], 1,0);
            if (k == 9)
                checkOutput("len_early_eop_out", 64'({engVal, engEop}), 64'b11);
        end
        checkOutput("len_pre_err", 64'(error), 64'd0);
        applyStimulus(0,0,0,0, 64'h0, 0,0);
        checkOutput("len_err", 64'(error), 64'd1);
        checkOutput("len_state", 64'(state), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
